// File: rtl/mag_comp_arbiter_pkg.sv
// mag_comp_pkg: shared types and constants for the mag_comp_arbiter slice.
//   state_t  : arbiter FSM states (IDLE -> GRANT -> CMP -> RESP -> IDLE)
//   W_DEF    : default operand width
//   LATENCY  : cycles from req sampled in IDLE to the done pulse (RESP cycle)
package mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CMP   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int W_DEF   = 16;
  localparam int LATENCY = 3;

  // Index width for a requester count; never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_comp_arbiter_if.sv
// mag_comp_arbiter_if: request/result bus between the client FSMs and the
// shared compare resource.
//   req    : per-requester level request
//   a_bus  : operand A per requester, slice i = [i*W +: W]
//   b_bus  : operand B per requester, same packing
//   gnt    : one-hot requester being served
//   done   : one-cycle pulse on the served requester's bit
//   AeqB/AgtB/AltB : registered compare result
//   busy   : arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface mag_comp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ*W-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              AeqB;
  logic              AgtB;
  logic              AltB;
  logic              busy;

  modport master (
    output req, a_bus, b_bus,
    input  gnt, done, AeqB, AgtB, AltB, busy
  );

  modport slave (
    input  req, a_bus, b_bus,
    output gnt, done, AeqB, AgtB, AltB, busy
  );
endinterface

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: combinational round-robin pick.
//   req     : request vector
//   ptr     : index where the search starts (highest priority)
//   gntNext : one-hot winner (0 when no request)
//   gntIdx  : binary index of the winner
//   anyReq  : at least one request present
// Search runs upward from ptr and wraps past NREQ-1 back to 0.
module rr_arbiter_core #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gntNext,
  output logic [IW-1:0]   gntIdx,
  output logic            anyReq
);

  always_comb begin
    int c;
    c       = 0;
    gntNext = '0;
    gntIdx  = '0;
    anyReq  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!anyReq && req[c]) begin
        anyReq     = 1'b1;
        gntIdx     = IW'(c);
        gntNext[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mag_comp_arbiter.sv
// mag_comp_arbiter: one registered W-bit magnitude comparator shared by NREQ
// requesters under round-robin arbitration.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mag_comp_arbiter_if.slave (req/operands in, gnt/done/results out)
// Build option: define MAG_COMP_SIGNED_EN to compare operands as two's
// complement; otherwise the compare is unsigned. Ports and timing match.
// Timing: req seen in IDLE -> GRANT (gnt valid) -> CMP (operands held)
// -> RESP (done pulse, results valid) -> IDLE; one compare per 4 cycles.
module mag_comp_arbiter
  import mag_comp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mag_comp_arbiter_if.slave bus
);

  localparam int IW = idxWidth(NREQ);

  state_t          state, stateNext;
  logic [IW-1:0]   ptr, winIdx, pickIdx;
  logic [NREQ-1:0] pickOh, gntR, doneR;
  logic            pickAny;
  logic [W-1:0]    opA, opB;
  logic            eqR, gtR, ltR;
  logic            eqC, gtC, ltC;

  rr_arbiter_core #(.NREQ(NREQ), .IW(IW)) uPick (
    .req     (bus.req),
    .ptr     (ptr),
    .gntNext (pickOh),
    .gntIdx  (pickIdx),
    .anyReq  (pickAny)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pickAny) stateNext = GRANT;
      GRANT:   stateNext = CMP;
      CMP:     stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Compare on the captured operands only, so bus changes after GRANT
  // cannot leak into the result.
  always_comb begin
    eqC = (opA == opB);
`ifdef MAG_COMP_SIGNED_EN
    gtC = ($signed(opA) > $signed(opB));
    ltC = ($signed(opA) < $signed(opB));
`else
    gtC = (opA > opB);
    ltC = (opA < opB);
`endif
  end

  // Datapath: grant, operand capture, result and done registers.
  // done is loaded on the CMP->RESP edge so it is high exactly in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      winIdx <= '0;
      gntR   <= '0;
      doneR  <= '0;
      opA    <= '0;
      opB    <= '0;
      eqR    <= 1'b0;
      gtR    <= 1'b0;
      ltR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickAny) begin
            gntR   <= pickOh;
            winIdx <= pickIdx;
          end
        end
        GRANT: begin
          opA <= bus.a_bus[int'(winIdx)*W +: W];
          opB <= bus.b_bus[int'(winIdx)*W +: W];
        end
        CMP: begin
          eqR   <= eqC;
          gtR   <= gtC;
          ltR   <= ltC;
          doneR <= gntR;
        end
        RESP: begin
          doneR <= '0;
          gntR  <= '0;
          // Winner drops to lowest priority for the next search.
          ptr   <= (winIdx == IW'(NREQ-1)) ? '0 : winIdx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt  = gntR;
  assign bus.done = doneR;
  assign bus.AeqB = eqR;
  assign bus.AgtB = gtR;
  assign bus.AltB = ltR;
  assign bus.busy = (state != IDLE);

endmodule
